// File: rtl/blinky_sequencer_if.sv
// Command channel between a command source (CPU/CSR or test logic) and
// blinky_sequencer.
//   cmd_valid  : request from the source
//   cmd_ready  : accept from the sequencer; a transfer completes on valid && ready
//   cmd_pulses : number of pulses in the train
//   cmd_on_ms  : high time per pulse, ms
//   cmd_off_ms : low time between pulses, ms
//   cmd_repeat : loop the train forever (present only with BLINKY_SEQ_REPEAT_EN)
// Optional feature macro: BLINKY_SEQ_REPEAT_EN
interface blinky_sequencer_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned MS_W  = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_pulses;
  logic [MS_W-1:0]  cmd_on_ms;
  logic [MS_W-1:0]  cmd_off_ms;
`ifdef BLINKY_SEQ_REPEAT_EN
  logic             cmd_repeat;

  modport master (
    output cmd_valid, cmd_pulses, cmd_on_ms, cmd_off_ms, cmd_repeat,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_pulses, cmd_on_ms, cmd_off_ms, cmd_repeat,
    output cmd_ready
  );
`else
  modport master (
    output cmd_valid, cmd_pulses, cmd_on_ms, cmd_off_ms,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_pulses, cmd_on_ms, cmd_off_ms,
    output cmd_ready
  );
`endif
endinterface

// File: rtl/blinky_sequencer.sv
// Request-driven LED pulse-train sequencer. Each accepted command produces
// cmd_pulses pulses of cmd_on_ms high and cmd_off_ms low; abort cancels.
// All timing derives from clk_freq_hz through a millisecond prescaler.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   cmd   : command channel (blinky_sequencer_if.slave)
//   abort : cancel the running sequence (highest priority)
//   busy  : high while a sequence runs (registered)
//   done  : one-cycle strobe on normal completion (registered)
//   q     : LED drive (registered)
// Optional feature macro: BLINKY_SEQ_REPEAT_EN adds cmd_repeat for an
// endlessly looping train that ends only via abort or rst.
module blinky_sequencer #(
  parameter int unsigned clk_freq_hz = 50_000,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MS_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  blinky_sequencer_if.slave   cmd,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                q
);

  localparam int unsigned CPM   = clk_freq_hz / 1000;
  localparam int unsigned PRE_W = (CPM > 1) ? $clog2(CPM) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CPM - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  // Reject clock frequencies that do not give a whole number of cycles per ms
  generate
    if ((clk_freq_hz < 1000) || ((clk_freq_hz % 1000) != 0)) begin : g_bad_freq
      $error("blinky_sequencer: clk_freq_hz must be >= 1000 and a multiple of 1000");
    end
  endgenerate

  logic [1:0]       state, state_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic [MS_W-1:0]  dur, dur_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pulses_lat, pulses_nxt;
  logic [MS_W-1:0]  on_lat, on_nxt;
  logic [MS_W-1:0]  off_lat, off_nxt;
  logic             q_nxt, busy_nxt, done_nxt;
  logic             rep_c;
  logic             wrap_c, phase_end_c;
  logic [MS_W-1:0]  off_eff_c;

`ifdef BLINKY_SEQ_REPEAT_EN
  logic rep_lat, rep_nxt;
  assign rep_c = rep_lat;
`else
  assign rep_c = 1'b0;
`endif

  assign cmd.cmd_ready = (state == IDLE) && !abort;

  // A phase ends on the prescaler wrap of its final millisecond
  assign wrap_c      = (pre == PRE_MAX);
  assign phase_end_c = wrap_c && (dur == MS_W'(1));
  // Zero-length gaps are stretched to 1 ms so adjacent pulses stay distinct
  assign off_eff_c   = (off_lat == '0) ? MS_W'(1) : off_lat;

  // Register all state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      dur        <= '0;
      cnt        <= '0;
      pulses_lat <= '0;
      on_lat     <= '0;
      off_lat    <= '0;
`ifdef BLINKY_SEQ_REPEAT_EN
      rep_lat    <= 1'b0;
`endif
      q          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      dur        <= dur_nxt;
      cnt        <= cnt_nxt;
      pulses_lat <= pulses_nxt;
      on_lat     <= on_nxt;
      off_lat    <= off_nxt;
`ifdef BLINKY_SEQ_REPEAT_EN
      rep_lat    <= rep_nxt;
`endif
      q          <= q_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre;
    dur_nxt    = dur;
    cnt_nxt    = cnt;
    pulses_nxt = pulses_lat;
    on_nxt     = on_lat;
    off_nxt    = off_lat;
`ifdef BLINKY_SEQ_REPEAT_EN
    rep_nxt    = rep_lat;
`endif
    q_nxt      = q;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      pre_nxt   = '0;
      dur_nxt   = '0;
      cnt_nxt   = '0;
      q_nxt     = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            pulses_nxt = cmd.cmd_pulses;
            on_nxt     = cmd.cmd_on_ms;
            off_nxt    = cmd.cmd_off_ms;
`ifdef BLINKY_SEQ_REPEAT_EN
            rep_nxt    = cmd.cmd_repeat;
`endif
            if ((cmd.cmd_pulses == '0) || (cmd.cmd_on_ms == '0)) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = ON;
              pre_nxt   = '0;
              dur_nxt   = cmd.cmd_on_ms;
              cnt_nxt   = cmd.cmd_pulses;
              q_nxt     = 1'b1;
              busy_nxt  = 1'b1;
            end
          end
        end

        ON: begin
          if (phase_end_c) begin
            pre_nxt = '0;
            q_nxt   = 1'b0;
            if (cnt == CNT_W'(1)) begin
              if (rep_c) begin
                // Looping train: run the trailing gap, then reload the count
                state_nxt = OFF;
                dur_nxt   = off_eff_c;
                cnt_nxt   = pulses_lat;
              end else begin
                // Last pulse: skip the trailing gap and finish immediately
                state_nxt = IDLE;
                dur_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
              end
            end else begin
              state_nxt = OFF;
              dur_nxt   = off_eff_c;
              cnt_nxt   = cnt - CNT_W'(1);
            end
          end else if (wrap_c) begin
            pre_nxt = '0;
            dur_nxt = dur - MS_W'(1);
          end else begin
            pre_nxt = pre + PRE_W'(1);
          end
        end

        OFF: begin
          if (phase_end_c) begin
            state_nxt = ON;
            pre_nxt   = '0;
            dur_nxt   = on_lat;
            q_nxt     = 1'b1;
          end else if (wrap_c) begin
            pre_nxt = '0;
            dur_nxt = dur - MS_W'(1);
          end else begin
            pre_nxt = pre + PRE_W'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
          pre_nxt   = '0;
          dur_nxt   = '0;
          cnt_nxt   = '0;
          q_nxt     = 1'b0;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
